// File: rtl/seq_multiciclo.sv
// Multi-cycle sequencer for the nRisc core: FETCH/DECODE/EXEC/MEM/WB control.
// Drives the per-phase datapath strobes and handles the memory ready handshake.
//
// Ports:
//   Clock, Reset        single clock; asynchronous active-low reset
//   Start               begin execution (sampled in IDLE only)
//   OPcode              opcode from instruction register (valid from DECODE on)
//   Zero                ALU zero flag, used by beq in EXEC
//   MemReady            memory access complete (FETCH / MEM)
//   LerInstr, IREsc     instruction read request / IR load
//   LerMem, EscMem      data-memory read (lw) / write (sw) request
//   EscReg              register-file write enable
//   EscPc, PcFonte      PC write enable / PC source (00 +1, 01 branch, 10 jump)
//   Halted, Erro        stopped by halt / by memory timeout
//   Estado              current state (debug)
//   InstrCount          retired instructions, saturating

module seq_multiciclo #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TMO_W   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       OPcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             LerInstr,
    output logic             IREsc,
    output logic             LerMem,
    output logic             EscMem,
    output logic             EscReg,
    output logic             EscPc,
    output logic [1:0]       PcFonte,
    output logic             Halted,
    output logic             Erro,
    output logic [2:0]       Estado,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERRO   = 3'd7
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_JUMP = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic is_beq, is_jump, is_sw, is_lw, is_halt;
    logic timeout;

    // Unknown or ALU opcodes fall through to the add/move/slt path.
    always_comb begin
        is_beq  = 1'b0;
        is_jump = 1'b0;
        is_sw   = 1'b0;
        is_lw   = 1'b0;
        is_halt = 1'b0;
        case (OPcode)
            OP_BEQ:  is_beq  = 1'b1;
            OP_JUMP: is_jump = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Last allowed waiting cycle with no ready; ready in the same cycle wins.
    assign timeout = (wait_q == WAIT_LAST) && !MemReady;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        retire   = 1'b0;
        LerInstr = 1'b0;
        IREsc    = 1'b0;
        LerMem   = 1'b0;
        EscMem   = 1'b0;
        EscReg   = 1'b0;
        EscPc    = 1'b0;
        PcFonte  = 2'b00;
        Halted   = 1'b0;
        Erro     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                LerInstr = 1'b1;
                if (MemReady) begin
                    IREsc   = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = ERRO;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    retire  = 1'b1;
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    EscPc   = 1'b1;
                    PcFonte = Zero ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = FETCH;
                    wait_d  = '0;
                end else if (is_jump) begin
                    EscPc   = 1'b1;
                    PcFonte = 2'b10;
                    retire  = 1'b1;
                    state_d = FETCH;
                    wait_d  = '0;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                // Anything but sw in MEM is handled as a load.
                EscMem = is_sw;
                LerMem = !is_sw;
                if (MemReady) begin
                    if (is_sw) begin
                        EscPc   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout) begin
                    state_d = ERRO;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WB: begin
                EscReg  = 1'b1;
                EscPc   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
                wait_d  = '0;
            end
            HALT: begin
                Halted = 1'b1;
            end
            ERRO: begin
                Erro = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign Estado     = state_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_seq_multiciclo.sv
// Scoreboard bench for seq_multiciclo: directed cycle vectors queued by the
// driver, compared at the falling edge by an independent monitor.

module tb_seq_multiciclo;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] BEQ = 3'b011;
    localparam logic [2:0] JMP = 3'b100;
    localparam logic [2:0] SW  = 3'b101;
    localparam logic [2:0] LW  = 3'b110;
    localparam logic [2:0] HLT = 3'b111;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  OPcode = 3'b000;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;

    logic        LerInstr, IREsc, LerMem, EscMem, EscReg, EscPc;
    logic [1:0]  PcFonte;
    logic        Halted, Erro;
    logic [2:0]  Estado;
    logic [15:0] InstrCount;

    logic        LerInstr2, IREsc2, LerMem2, EscMem2, EscReg2, EscPc2;
    logic [1:0]  PcFonte2;
    logic        Halted2, Erro2;
    logic [2:0]  Estado2;
    logic [1:0]  InstrCount2;

    logic [9:0]  outs;
    assign outs = {LerInstr, IREsc, LerMem, EscMem, EscReg,
                   EscPc, PcFonte, Halted, Erro};

    seq_multiciclo #(.CNT_W(16), .TIMEOUT(15), .TMO_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .OPcode(OPcode),
        .Zero(Zero), .MemReady(MemReady),
        .LerInstr(LerInstr), .IREsc(IREsc), .LerMem(LerMem),
        .EscMem(EscMem), .EscReg(EscReg), .EscPc(EscPc),
        .PcFonte(PcFonte), .Halted(Halted), .Erro(Erro),
        .Estado(Estado), .InstrCount(InstrCount)
    );

    seq_multiciclo #(.CNT_W(2), .TIMEOUT(15), .TMO_W(4)) dut2 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .OPcode(OPcode),
        .Zero(Zero), .MemReady(MemReady),
        .LerInstr(LerInstr2), .IREsc(IREsc2), .LerMem(LerMem2),
        .EscMem(EscMem2), .EscReg(EscReg2), .EscPc(EscPc2),
        .PcFonte(PcFonte2), .Halted(Halted2), .Erro(Erro2),
        .Estado(Estado2), .InstrCount(InstrCount2)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  o;
        logic [15:0] c;
        logic [1:0]  c2;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input logic s, input logic [2:0] op, input logic z,
                       input logic mr, input logic [2:0] es,
                       input logic [9:0] eo, input int ec);
        exp_t e;
        Start    = s;
        OPcode   = op;
        Zero     = z;
        MemReady = mr;
        e.st = es;
        e.o  = eo;
        e.c  = 16'(ec);
        e.c2 = (ec > 3) ? 2'd3 : 2'(ec);
        q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b0;
        cyc(0, ADD, 0, 0, 3'd0, 10'h000, 0);
        cyc(0, ADD, 0, 0, 3'd0, 10'h000, 0);
        Reset = 1'b1;
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vecs++;
            if ({Estado, outs, InstrCount, InstrCount2} !==
                {e.st, e.o, e.c, e.c2}) begin
                errs++;
                $display("FAIL vec%0d: Estado=%0d out=%h cnt=%0d cnt2=%0d, want Estado=%0d out=%h cnt=%0d cnt2=%0d",
                         vecs, Estado, outs, InstrCount, InstrCount2,
                         e.st, e.o, e.c, e.c2);
            end
        end
    end

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        do_reset;

        // add, lw, sw, halt with zero-wait memory
        cyc(1, ADD, 0, 1, 3'd0, 10'h000, 0);
        cyc(0, ADD, 0, 1, 3'd1, 10'h300, 0);
        cyc(0, ADD, 0, 1, 3'd2, 10'h000, 0);
        cyc(0, ADD, 0, 1, 3'd3, 10'h000, 0);
        cyc(0, ADD, 0, 1, 3'd5, 10'h030, 0);
        cyc(0, LW,  0, 1, 3'd1, 10'h300, 1);
        cyc(0, LW,  0, 1, 3'd2, 10'h000, 1);
        cyc(0, LW,  0, 1, 3'd3, 10'h000, 1);
        cyc(0, LW,  0, 1, 3'd4, 10'h080, 1);
        cyc(0, LW,  0, 1, 3'd5, 10'h030, 1);
        cyc(0, SW,  0, 1, 3'd1, 10'h300, 2);
        cyc(0, SW,  0, 1, 3'd2, 10'h000, 2);
        cyc(0, SW,  0, 1, 3'd3, 10'h000, 2);
        cyc(0, SW,  0, 1, 3'd4, 10'h050, 2);
        cyc(0, HLT, 0, 1, 3'd1, 10'h300, 3);
        cyc(0, HLT, 0, 1, 3'd2, 10'h000, 3);
        cyc(1, HLT, 0, 1, 3'd6, 10'h002, 4);
        cyc(1, HLT, 0, 1, 3'd6, 10'h002, 4);
        do_reset;

        // beq taken / not taken, jump, then reset in the middle of lw MEM
        cyc(1, BEQ, 1, 1, 3'd0, 10'h000, 0);
        cyc(0, BEQ, 1, 1, 3'd1, 10'h300, 0);
        cyc(0, BEQ, 1, 1, 3'd2, 10'h000, 0);
        cyc(0, BEQ, 1, 1, 3'd3, 10'h014, 0);
        cyc(0, BEQ, 0, 1, 3'd1, 10'h300, 1);
        cyc(0, BEQ, 0, 1, 3'd2, 10'h000, 1);
        cyc(0, BEQ, 0, 1, 3'd3, 10'h010, 1);
        cyc(0, JMP, 0, 1, 3'd1, 10'h300, 2);
        cyc(0, JMP, 0, 1, 3'd2, 10'h000, 2);
        cyc(0, JMP, 0, 1, 3'd3, 10'h018, 2);
        cyc(0, LW,  0, 1, 3'd1, 10'h300, 3);
        cyc(0, LW,  0, 1, 3'd2, 10'h000, 3);
        cyc(0, LW,  0, 1, 3'd3, 10'h000, 3);
        cyc(0, LW,  0, 0, 3'd4, 10'h080, 3);
        do_reset;

        // five retires: 16-bit counter 1..5, 2-bit counter saturates at 3
        cyc(1, BEQ, 0, 1, 3'd0, 10'h000, 0);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] op;
            logic [9:0] eo;
            op = (i < 3) ? BEQ : JMP;
            eo = (i < 3) ? 10'h010 : 10'h018;
            cyc(0, op, 0, 1, 3'd1, 10'h300, i);
            cyc(0, op, 0, 1, 3'd2, 10'h000, i);
            cyc(0, op, 0, 1, 3'd3, eo, i);
        end
        cyc(0, ADD, 0, 0, 3'd1, 10'h200, 5);
        do_reset;

        // instruction fetch timeout, then ERRO is absorbing
        cyc(1, ADD, 0, 0, 3'd0, 10'h000, 0);
        repeat (15) cyc(0, ADD, 0, 0, 3'd1, 10'h200, 0);
        cyc(0, ADD, 0, 0, 3'd7, 10'h001, 0);
        repeat (3) cyc(1, ADD, 0, 1, 3'd7, 10'h001, 0);
        do_reset;

        // slow fetch, then sw ready on the 15th MEM cycle: no error
        cyc(1, SW, 0, 0, 3'd0, 10'h000, 0);
        repeat (10) cyc(0, SW, 0, 0, 3'd1, 10'h200, 0);
        cyc(0, SW, 0, 1, 3'd1, 10'h300, 0);
        cyc(0, SW, 0, 1, 3'd2, 10'h000, 0);
        cyc(0, SW, 0, 1, 3'd3, 10'h000, 0);
        repeat (14) cyc(0, SW, 0, 0, 3'd4, 10'h040, 0);
        cyc(0, SW, 0, 1, 3'd4, 10'h050, 0);
        cyc(0, SW, 0, 0, 3'd1, 10'h200, 1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clock);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
